mux_scan_sequencer: RTL and testbench

- Upstream control stage for the registered 8:1 multiplexer. It generates the 3-bit channel select by scanning a programmable set of enabled channels.
- Each selected channel is held for a programmable dwell time. A sample strobe is emitted so the downstream consumer knows when the mux output is stable.
- Supports single-pass and continuous scanning, abort, and error flagging of an empty channel mask.

---
 rtl/mux_scan_sequencer.sv | 147 ++++++++++++++
 tb/tb_mux_scan_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// Channel-select sequencer for a registered 8:1 mux: scans the enabled channels, holding each for dwell+1 cycles.
// Latency: sel/sel_valid/busy follow an accepted start by one cycle; done/err are registered one-cycle pulses.
// Backpressure: none; stop aborts a scan, and start is only looked at while idle.
module mux_scan_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [7:0]         ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               sel_valid,
    output logic               sample,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [7:0]         mask_q, mask_d;
    logic               mode_q, mode_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [2:0]         in_low;
    logic [2:0]         sh_low;
    logic [2:0]         sh_next;
    logic               sh_has_next;

    // Priority encoders: lowest set bit of the live and shadow masks, and the
    // next shadow channel strictly above the current select.
    always_comb begin
        in_low      = '0;
        sh_low      = '0;
        sh_next     = '0;
        sh_has_next = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (ch_mask[i]) begin
                in_low = 3'(i);
            end
            if (mask_q[i]) begin
                sh_low = 3'(i);
            end
            if (mask_q[i] && (i > int'(sel_q))) begin
                sh_next     = 3'(i);
                sh_has_next = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                sel_d = '0;
                cnt_d = '0;
                if (start && !stop) begin
                    if (ch_mask != 8'h00) begin
                        mask_d  = ch_mask;
                        dwell_d = dwell;
                        mode_d  = mode;
                        sel_d   = in_low;
                        cnt_d   = dwell;
                        state_d = SCAN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (stop) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (sh_has_next) begin
                    sel_d = sh_next;
                    cnt_d = dwell_q;
                end else if (mode_q) begin
                    sel_d = sh_low;
                    cnt_d = dwell_q;
                end else begin
                    state_d = IDLE;
                    sel_d   = '0;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            mask_q  <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // All outputs are decoded from registers only.
    assign sel       = sel_q;
    assign sel_valid = (state_q == SCAN);
    assign busy      = (state_q == SCAN);
    assign sample    = (state_q == SCAN) && (cnt_q == '0);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: directed test-plan scans plus random scans checked against a per-cycle trace model.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] ch_mask;
    logic [3:0] dwell;
    logic [2:0] sel;
    logic       sel_valid;
    logic       sample;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    mux_scan_sequencer #(.DWELL_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .ch_mask   (ch_mask),
        .dwell     (dwell),
        .sel       (sel),
        .sel_valid (sel_valid),
        .sample    (sample),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then examined 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic exp_done, input logic exp_err);
        chk({tag, ".sel"},       32'(sel),       32'd0);
        chk({tag, ".sel_valid"}, 32'(sel_valid), 32'd0);
        chk({tag, ".busy"},      32'(busy),      32'd0);
        chk({tag, ".sample"},    32'(sample),    32'd0);
        chk({tag, ".done"},      32'(done),      32'(exp_done));
        chk({tag, ".err"},       32'(err),       32'(exp_err));
    endtask

    // Starts a scan and checks every SCAN cycle against the trace implied by the
    // mask: channels ascending, each repeated dwell+1 times, sample on the last.
    // stop_at>0 raises stop during that SCAN cycle; cont_len bounds continuous runs.
    // Single-pass runs end having checked the done cycle (no extra edge).
    task automatic do_scan(input string tag, input logic [7:0] m, input logic [3:0] d,
                           input logic md, input int stop_at, input int cont_len,
                           input logic perturb);
        int chans[8];
        int n;
        int total;
        int per;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                chans[n] = i;
                n++;
            end
        end
        per   = int'(d) + 1;
        total = md ? cont_len : n * per;
        if (stop_at > 0 && stop_at < total) total = stop_at;

        ch_mask = m;
        dwell   = d;
        mode    = md;
        stop    = 1'b0;
        start   = 1'b1;
        step();
        start   = 1'b0;

        for (int k = 1; k <= total; k++) begin
            int idx;
            idx = (k - 1) / per;
            chk({tag, ".scan_sel"},    32'(sel),       32'(chans[idx % n]));
            chk({tag, ".scan_sample"}, 32'(sample),    32'(((k - 1) % per) == (per - 1)));
            chk({tag, ".scan_busy"},   32'(busy),      32'd1);
            chk({tag, ".scan_valid"},  32'(sel_valid), 32'd1);
            chk({tag, ".scan_done"},   32'(done),      32'd0);
            start = 1'b0;
            if (perturb && k == 2) begin
                ch_mask = ~m;
                dwell   = 4'd5;
                mode    = ~md;
                start   = 1'b1;
            end
            if (k == stop_at) stop = 1'b1;
            step();
        end
        start = 1'b0;
        if (stop) begin
            stop = 1'b0;
            chk_idle({tag, ".after_stop"}, 1'b0, 1'b0);
        end else if (md) begin
            stop = 1'b1;
            step();
            stop = 1'b0;
            chk_idle({tag, ".after_cont_stop"}, 1'b0, 1'b0);
        end else begin
            chk_idle({tag, ".done_cycle"}, 1'b1, 1'b0);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        mode    = 1'b0;
        ch_mask = 8'h00;
        dwell   = 4'd0;
        step();
        step();
        rst = 1'b0;
        chk_idle("reset", 1'b0, 1'b0);

        // Full sweep, then a start accepted in the done cycle.
        do_scan("sweep", 8'hFF, 4'd0, 1'b0, 0, 0, 1'b0);
        do_scan("b2b", 8'b1010_0100, 4'd2, 1'b0, 0, 0, 1'b0);
        step();
        chk_idle("post_sparse", 1'b0, 1'b0);

        do_scan("cont_stop", 8'h81, 4'd1, 1'b1, 5, 100, 1'b0);
        step();
        chk_idle("cont_stop_quiet", 1'b0, 1'b0);

        // Empty mask raises err for exactly one cycle.
        ch_mask = 8'h00;
        start   = 1'b1;
        step();
        start = 1'b0;
        chk_idle("empty", 1'b0, 1'b1);
        step();
        chk_idle("empty_next", 1'b0, 1'b0);

        // start together with stop: stop wins.
        ch_mask = 8'hFF;
        start   = 1'b1;
        stop    = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk_idle("start_stop", 1'b0, 1'b0);
        step();
        chk_idle("start_stop_next", 1'b0, 1'b0);

        // Reset on the third SCAN cycle of a dwell=3 scan.
        ch_mask = 8'hFF;
        dwell   = 4'd3;
        mode    = 1'b0;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            chk("rst_scan_busy", 32'(busy), 32'd1);
            chk("rst_scan_sample", 32'(sample), 32'(k == 4));
            if (k == 3) rst = 1'b1;
            step();
        end
        rst = 1'b0;
        chk_idle("mid_reset", 1'b0, 1'b0);

        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        chk_idle("rst_start", 1'b0, 1'b0);
        step();
        chk_idle("rst_start_next", 1'b0, 1'b0);

        // Live inputs changed mid-scan must not disturb the shadowed pass.
        do_scan("shadow", 8'h0F, 4'd1, 1'b0, 0, 0, 1'b1);
        step();
        chk_idle("shadow_next", 1'b0, 1'b0);

        do_scan("single_ch", 8'h10, 4'd2, 1'b1, 0, 12, 1'b0);

        for (int r = 0; r < 25; r++) begin
            logic [7:0] m;
            logic [3:0] d;
            logic       md;
            int         n;
            int         sa;
            m  = 8'($urandom_range(1, 255));
            d  = 4'($urandom_range(0, 4));
            md = 1'($urandom_range(0, 1));
            n  = $countones(m);
            sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, n * (int'(d) + 1))) : 0;
            do_scan("random", m, d, md, sa, 2 * n * (int'(d) + 1) + 3, 1'($urandom_range(0, 1)));
            step();
            chk_idle("random_gap", 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
